// File: rtl/clk_freq_monitor_pkg.sv
// clk_freq_monitor_pkg
//   Shared definitions for the clock frequency monitor:
//   lock FSM state encoding, estimator word field positions and
//   the frequency window test.
package clk_freq_monitor_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACQ    = 2'd1,
        LOCKED = 2'd2,
        STALL  = 2'd3
    } mon_state_t;

    // Event counter field inside the 32-bit estimator word
    localparam int EVNT_MSB = 31;
    localparam int EVNT_LSB = 28;

    // Inclusive unsigned window test; lo > hi yields an empty window.
    // Arguments are widened to the largest legal count width.
    function automatic logic in_window(input logic [27:0] value,
                                       input logic [27:0] lo,
                                       input logic [27:0] hi);
        return (value >= lo) && (value <= hi);
    endfunction

endpackage

// File: rtl/clk_mon_timeout.sv
// clk_mon_timeout
//   Saturating stall-timeout counter for the clock frequency monitor.
//   Ports:
//     clk     - measured clock
//     rst     - asynchronous active-high reset
//     clear   - restart counting from zero (a new measurement arrived)
//     expired - counter has reached all ones (held until cleared)
module clk_mon_timeout #(
    parameter int unsigned TIMEOUT_BITS = 24
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    output logic expired
);

    logic [TIMEOUT_BITS-1:0] cnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt <= '0;
        end else if (clear) begin
            cnt <= '0;
        end else if (cnt != '1) begin
            cnt <= cnt + 1'b1;
        end
    end

    assign expired = (cnt == '1);

endmodule

// File: rtl/clk_freq_monitor.sv
// clk_freq_monitor
//   Consumes the estimator word {evnts[3:0], pad, period count}, detects
//   each new measurement (change of evnts), checks it against a runtime
//   window and runs a lock/unlock FSM with hysteresis. Tracks last/min/max
//   counts, a saturating out-of-window count, and flags a stalled clock.
//   Ports:
//     clk, rst        - measured clock, asynchronous active-high reset
//     cntr_valid      - estimator word valid
//     cntr_ready      - monitor ready (high from first edge after reset)
//     cntr_data       - [31:28] event counter, [EST_BITS-1:0] period count
//     cfg_lo, cfg_hi  - inclusive window bounds
//     clr             - one-cycle clear of min/max/err statistics
//     stat_valid      - pulse: accepted measurement reflected in stats
//     stat_locked     - lock status
//     stat_stalled    - no measurement within the timeout
//     stat_last/min/max - last, minimum and maximum accepted counts
//     stat_err_cnt    - out-of-window accepted samples, saturating
//     irq             - pulse on every change of stat_locked
module clk_freq_monitor
    import clk_freq_monitor_pkg::*;
#(
    parameter int unsigned EST_BITS     = 20,
    parameter int unsigned LOCK_CNT     = 4,
    parameter int unsigned UNLOCK_CNT   = 2,
    parameter int unsigned TIMEOUT_BITS = 24
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                cntr_valid,
    output logic                cntr_ready,
    input  logic [31:0]         cntr_data,
    input  logic [EST_BITS-1:0] cfg_lo,
    input  logic [EST_BITS-1:0] cfg_hi,
    input  logic                clr,
    output logic                stat_valid,
    output logic                stat_locked,
    output logic                stat_stalled,
    output logic [EST_BITS-1:0] stat_last,
    output logic [EST_BITS-1:0] stat_min,
    output logic [EST_BITS-1:0] stat_max,
    output logic [7:0]          stat_err_cnt,
    output logic                irq
);

    localparam int unsigned GW = $clog2(LOCK_CNT + 1);
    localparam int unsigned BW = $clog2(UNLOCK_CNT + 1);

    mon_state_t          state;
    logic [3:0]          prev_evnts;
    logic [GW-1:0]       good_cnt;
    logic [BW-1:0]       bad_cnt;

    logic [3:0]          evnts;
    logic [EST_BITS-1:0] count;
    logic                new_event;
    logic                in_win;
    logic                accept;
    logic                expired;
    logic [GW-1:0]       good_nxt;
    logic [BW-1:0]       bad_nxt;

    assign evnts     = cntr_data[EVNT_MSB:EVNT_LSB];
    assign count     = cntr_data[EST_BITS-1:0];
    // Any change of the event field is exactly one event, including 15->0
    assign new_event = cntr_valid && cntr_ready && (evnts != prev_evnts);
    assign in_win    = in_window(28'(count), 28'(cfg_lo), 28'(cfg_hi));
    // Events seen in IDLE/STALL are partial periods and never reach the stats
    assign accept    = new_event && ((state == ACQ) || (state == LOCKED));
    assign good_nxt  = good_cnt + 1'b1;
    assign bad_nxt   = bad_cnt + 1'b1;

    generate
        if (EST_BITS < 28) begin : g_pad
            logic unused_pad;
            assign unused_pad = ^cntr_data[EVNT_LSB-1:EST_BITS];
        end
    endgenerate

    clk_mon_timeout #(
        .TIMEOUT_BITS(TIMEOUT_BITS)
    ) u_timeout (
        .clk    (clk),
        .rst    (rst),
        .clear  (new_event),
        .expired(expired)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cntr_ready   <= 1'b0;
            stat_valid   <= 1'b0;
            stat_locked  <= 1'b0;
            stat_stalled <= 1'b0;
            stat_last    <= '0;
            stat_min     <= '1;
            stat_max     <= '0;
            stat_err_cnt <= '0;
            irq          <= 1'b0;
            prev_evnts   <= '0;
            state        <= IDLE;
            good_cnt     <= '0;
            bad_cnt      <= '0;
        end else begin
            cntr_ready <= 1'b1;
            stat_valid <= accept;
            irq        <= 1'b0;

            if (new_event) begin
                prev_evnts <= evnts;
            end

            if (accept) begin
                stat_last <= count;
            end

            // clr wins over a coincident sample for min/max/err only
            if (clr) begin
                stat_min     <= '1;
                stat_max     <= '0;
                stat_err_cnt <= '0;
            end else if (accept) begin
                if (count < stat_min) stat_min <= count;
                if (count > stat_max) stat_max <= count;
                if (!in_win && (stat_err_cnt != 8'hFF)) begin
                    stat_err_cnt <= stat_err_cnt + 8'd1;
                end
            end

            // A real event in the expiry cycle is a valid measurement and wins
            if (new_event) begin
                case (state)
                    IDLE: begin
                        state    <= ACQ;
                        good_cnt <= '0;
                    end
                    STALL: begin
                        state        <= ACQ;
                        good_cnt     <= '0;
                        stat_stalled <= 1'b0;
                    end
                    ACQ: begin
                        if (in_win) begin
                            if (good_nxt == GW'(LOCK_CNT)) begin
                                state       <= LOCKED;
                                bad_cnt     <= '0;
                                stat_locked <= 1'b1;
                                irq         <= 1'b1;
                            end else begin
                                good_cnt <= good_nxt;
                            end
                        end else begin
                            good_cnt <= '0;
                        end
                    end
                    LOCKED: begin
                        if (!in_win) begin
                            if (bad_nxt == BW'(UNLOCK_CNT)) begin
                                state       <= ACQ;
                                good_cnt    <= '0;
                                stat_locked <= 1'b0;
                                irq         <= 1'b1;
                            end else begin
                                bad_cnt <= bad_nxt;
                            end
                        end else begin
                            bad_cnt <= '0;
                        end
                    end
                    default: state <= IDLE;
                endcase
            end else if (expired && (state != STALL)) begin
                state        <= STALL;
                good_cnt     <= '0;
                stat_stalled <= 1'b1;
                stat_locked  <= 1'b0;
                irq          <= stat_locked;
            end
        end
    end

endmodule

// File: tb/tb_clk_freq_monitor.sv
module tb_clk_freq_monitor;

    logic        clk = 1'b0;
    logic        rst;
    logic        cntr_valid;
    logic        cntr_ready;
    logic [31:0] cntr_data;
    logic [19:0] cfg_lo, cfg_hi;
    logic        clr;
    logic        stat_valid, stat_locked, stat_stalled, irq;
    logic [19:0] stat_last, stat_min, stat_max;
    logic [7:0]  stat_err_cnt;

    int vectors = 0;
    int miscompares = 0;

    typedef struct packed {
        logic        valid;
        logic        locked;
        logic        irq;
        logic        stalled;
        logic [19:0] last;
        logic [19:0] min;
        logic [19:0] max;
        logic [7:0]  err;
    } exp_t;

    exp_t sb[$];

    always #5 clk = ~clk;

    clk_freq_monitor #(
        .EST_BITS    (20),
        .LOCK_CNT    (4),
        .UNLOCK_CNT  (2),
        .TIMEOUT_BITS(8)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .cntr_valid  (cntr_valid),
        .cntr_ready  (cntr_ready),
        .cntr_data   (cntr_data),
        .cfg_lo      (cfg_lo),
        .cfg_hi      (cfg_hi),
        .clr         (clr),
        .stat_valid  (stat_valid),
        .stat_locked (stat_locked),
        .stat_stalled(stat_stalled),
        .stat_last   (stat_last),
        .stat_min    (stat_min),
        .stat_max    (stat_max),
        .stat_err_cnt(stat_err_cnt),
        .irq         (irq)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_reset(input string tag);
        check({tag, ".ready"},   32'(cntr_ready),   32'd0);
        check({tag, ".valid"},   32'(stat_valid),   32'd0);
        check({tag, ".locked"},  32'(stat_locked),  32'd0);
        check({tag, ".stalled"}, 32'(stat_stalled), 32'd0);
        check({tag, ".last"},    32'(stat_last),    32'd0);
        check({tag, ".min"},     32'(stat_min),     32'hFFFFF);
        check({tag, ".max"},     32'(stat_max),     32'd0);
        check({tag, ".err"},     32'(stat_err_cnt), 32'd0);
        check({tag, ".irq"},     32'(irq),          32'd0);
    endtask

    // Drive one estimator word, queue its expected outcome, then compare
    // the stats visible in the cycle after the sampling edge.
    task automatic step(input string tag, input logic [3:0] ev, input logic [19:0] cnt,
                        input logic c, input logic v, input logic lk, input logic iq,
                        input logic st, input logic [19:0] l, input logic [19:0] mn,
                        input logic [19:0] mx, input logic [7:0] e);
        exp_t x;
        @(negedge clk);
        cntr_data = {ev, 8'h00, cnt};
        clr       = c;
        sb.push_back('{valid: v, locked: lk, irq: iq, stalled: st,
                       last: l, min: mn, max: mx, err: e});
        @(negedge clk);
        clr = 1'b0;
        if (sb.size() == 0) begin
            vectors++;
            miscompares++;
            $error("FAIL %s: observed empty scoreboard expected one entry", tag);
        end else begin
            x = sb.pop_front();
            check({tag, ".valid"},   32'(stat_valid),   32'(x.valid));
            check({tag, ".locked"},  32'(stat_locked),  32'(x.locked));
            check({tag, ".irq"},     32'(irq),          32'(x.irq));
            check({tag, ".stalled"}, 32'(stat_stalled), 32'(x.stalled));
            check({tag, ".last"},    32'(stat_last),    32'(x.last));
            check({tag, ".min"},     32'(stat_min),     32'(x.min));
            check({tag, ".max"},     32'(stat_max),     32'(x.max));
            check({tag, ".err"},     32'(stat_err_cnt), 32'(x.err));
        end
    endtask

    initial begin
        int waited;
        rst        = 1'b1;
        cntr_valid = 1'b0;
        cntr_data  = '0;
        clr        = 1'b0;
        cfg_lo     = 20'd1000;
        cfg_hi     = 20'd1100;
        repeat (2) @(negedge clk);
        check_reset("reset");

        rst        = 1'b0;
        cntr_valid = 1'b1;
        @(negedge clk);
        check("ready_after_reset", 32'(cntr_ready), 32'd1);

        // Acquire lock: first event discarded, lock on the 5th
        step("acq1", 4'd1, 20'd7,    0, 0, 0, 0, 0, 20'd0,    20'hFFFFF, 20'd0,    8'd0);
        step("acq2", 4'd2, 20'd1050, 0, 1, 0, 0, 0, 20'd1050, 20'd1050,  20'd1050, 8'd0);
        step("acq3", 4'd3, 20'd1050, 0, 1, 0, 0, 0, 20'd1050, 20'd1050,  20'd1050, 8'd0);
        step("acq4", 4'd4, 20'd1050, 0, 1, 0, 0, 0, 20'd1050, 20'd1050,  20'd1050, 8'd0);
        step("acq5", 4'd5, 20'd1050, 0, 1, 1, 1, 0, 20'd1050, 20'd1050,  20'd1050, 8'd0);

        // Hysteresis: one bad, one good, two bad -> unlock
        step("unl1", 4'd6, 20'd1200, 0, 1, 1, 0, 0, 20'd1200, 20'd1050, 20'd1200, 8'd1);
        step("unl2", 4'd7, 20'd1050, 0, 1, 1, 0, 0, 20'd1050, 20'd1050, 20'd1200, 8'd1);
        step("unl3", 4'd8, 20'd1200, 0, 1, 1, 0, 0, 20'd1200, 20'd1050, 20'd1200, 8'd2);
        step("unl4", 4'd9, 20'd1200, 0, 1, 0, 1, 0, 20'd1200, 20'd1050, 20'd1200, 8'd3);

        // Stall: no event change, bounded wait
        waited = 0;
        while (!stat_stalled && waited < 400) begin
            @(negedge clk);
            waited++;
        end
        check("stall.flag",    32'(stat_stalled), 32'd1);
        check("stall.latency", 32'(waited >= 250 && waited <= 260), 32'd1);
        check("stall.locked",  32'(stat_locked),  32'd0);
        step("stall_exit", 4'd10, 20'd5, 0, 0, 0, 0, 0, 20'd1200, 20'd1050, 20'd1200, 8'd3);

        // Wrap 14,15,0,1: four accepted events re-acquire lock
        step("wrap14", 4'd14, 20'd1050, 0, 1, 0, 0, 0, 20'd1050, 20'd1050, 20'd1200, 8'd3);
        step("wrap15", 4'd15, 20'd1050, 0, 1, 0, 0, 0, 20'd1050, 20'd1050, 20'd1200, 8'd3);
        step("wrap0",  4'd0,  20'd1050, 0, 1, 0, 0, 0, 20'd1050, 20'd1050, 20'd1200, 8'd3);
        step("wrap1",  4'd1,  20'd1050, 0, 1, 1, 1, 0, 20'd1050, 20'd1050, 20'd1200, 8'd3);

        // clr coincident with an accepted out-of-window sample
        step("clr900", 4'd2, 20'd900,  1, 1, 1, 0, 0, 20'd900,  20'hFFFFF, 20'd0,    8'd0);
        step("postclr",4'd3, 20'd1050, 0, 1, 1, 0, 0, 20'd1050, 20'd1050,  20'd1050, 8'd0);

        // Asynchronous reset mid-cycle, then an empty window
        @(negedge clk);
        #2 rst = 1'b1;
        #1 check_reset("midreset");
        cntr_data = '0;
        cfg_lo    = 20'd1100;
        cfg_hi    = 20'd1000;
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        for (int i = 1; i <= 10; i++) begin
            step($sformatf("empty%0d", i), 4'(i), 20'd1050, 0, (i > 1), 0, 0, 0,
                 (i > 1) ? 20'd1050 : 20'd0,
                 (i > 1) ? 20'd1050 : 20'hFFFFF,
                 (i > 1) ? 20'd1050 : 20'd0,
                 8'(i - 1));
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
